// File: rtl/tape_player_if.sv
// Loader-side byte handshake for tape_player.
//   di  : byte from the loader
//   dv  : di valid
//   dl  : di is the last byte of a block (qualified by dv)
//   rdy : player FIFO can accept a byte (not full)
// master = loader side, slave = tape_player side.
interface tape_player_if;
  logic [7:0] di;
  logic       dv;
  logic       dl;
  logic       rdy;

  modport master (output di, output dv, output dl, input rdy);
  modport slave  (input di, input dv, input dl, output rdy);
endinterface

// File: rtl/tape_player.sv
// Cassette-signal generator for the CPU EAR input.
// Bytes pushed through a small FIFO are played as a pulse-width-encoded
// square wave: pilot tone, one sync cycle, data bits MSB first, then an
// ear-low gap. One symbol is ear=1 for H ce ticks followed by ear=0 for
// H ce ticks. Playback only advances on ce=1 with the motor bit set.
//
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   ce    : timing enable, all half-period counting advances on ce=1
//   motor : tape motor bit, 0 freezes playback (FIFO still accepts)
//   tape  : loader handshake (di/dv/dl in, rdy out), slave modport
//   ear   : generated tape signal
//   busy  : a block is in progress
//   done  : one-clock pulse when the gap after a block ends
//
// Optional feature: define TAPE_CHECKSUM_EN to append the XOR of all data
// bytes of a block as one extra byte before the gap.
module tape_player #(
  parameter int DEPTH     = 16,
  parameter int HP0       = 40,
  parameter int HP1       = 80,
  parameter int HP_PILOT  = 60,
  parameter int PILOT_CYC = 768,
  parameter int HP_SYNC   = 20,
  parameter int GAP       = 4000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic         motor,
  tape_player_if.slave tape,
  output logic         ear,
  output logic         busy,
  output logic         done
);
  localparam int AW   = $clog2(DEPTH);
  localparam int M1   = (HP0 > HP1) ? HP0 : HP1;
  localparam int M2   = (M1 > HP_PILOT) ? M1 : HP_PILOT;
  localparam int M3   = (M2 > HP_SYNC) ? M2 : HP_SYNC;
  localparam int MAXV = (M3 > GAP) ? M3 : GAP;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam int PW   = (PILOT_CYC > 1) ? $clog2(PILOT_CYC) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_PILOT, ST_SYNC, ST_DATA, ST_GAP} state_t;

  state_t state, stateNext;

  // FIFO of {dl, di}
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          push, pop, empty, rdyInt;
  logic [8:0]    rdData;

  // Symbol generator
  logic          step, hi, halfEnd, symDone, lastFlag;
  logic [CW-1:0] cnt;
  logic [PW-1:0] cycCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shreg;
`ifdef TAPE_CHECKSUM_EN
  logic [7:0]    csum;
  logic          csPhase;
`endif

  function automatic logic [CW-1:0] halfOf(input logic b);
    return b ? CW'(HP1 - 1) : CW'(HP0 - 1);
  endfunction

  always_comb begin
    empty    = (count == '0);
    rdyInt   = (count != FULL_CNT);
    tape.rdy = rdyInt;
    push     = tape.dv & rdyInt;
    rdData   = mem[rdPtr];
    step     = ce & motor;
    halfEnd  = (cnt == '0);
    symDone  = halfEnd & ~hi;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= {tape.dl, tape.di};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Underrun needs no extra state: a finished byte parks with hi=0, cnt=0,
  // bitCnt=0, so symDone re-fires on every step until a byte can be popped.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    if (step) begin
      unique case (state)
        ST_IDLE:  if (!empty) stateNext = ST_PILOT;
        ST_PILOT: if (symDone && cycCnt == '0) stateNext = ST_SYNC;
        ST_SYNC:  if (symDone) begin
                    stateNext = ST_DATA;
                    pop       = ~empty;
                  end
        ST_DATA:  if (symDone && bitCnt == '0) begin
                    if (lastFlag) begin
`ifdef TAPE_CHECKSUM_EN
                      if (csPhase) stateNext = ST_GAP;
`else
                      stateNext = ST_GAP;
`endif
                    end else begin
                      pop = ~empty;
                    end
                  end
        ST_GAP:   if (halfEnd) stateNext = ST_IDLE;
        default:  stateNext = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ear  = hi;
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi       <= 1'b0;
      cnt      <= '0;
      cycCnt   <= '0;
      bitCnt   <= '0;
      shreg    <= '0;
      lastFlag <= 1'b0;
      done     <= 1'b0;
`ifdef TAPE_CHECKSUM_EN
      csum     <= '0;
      csPhase  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (step) begin
        unique case (state)
          ST_IDLE: if (!empty) begin
            hi     <= 1'b1;
            cnt    <= CW'(HP_PILOT - 1);
            cycCnt <= PW'(PILOT_CYC - 1);
`ifdef TAPE_CHECKSUM_EN
            csum    <= '0;
            csPhase <= 1'b0;
`endif
          end
          ST_PILOT: begin
            if (!halfEnd) cnt <= cnt - CW'(1);
            else if (hi) begin
              hi  <= 1'b0;
              cnt <= CW'(HP_PILOT - 1);
            end else if (cycCnt == '0) begin
              hi  <= 1'b1;
              cnt <= CW'(HP_SYNC - 1);
            end else begin
              hi     <= 1'b1;
              cnt    <= CW'(HP_PILOT - 1);
              cycCnt <= cycCnt - PW'(1);
            end
          end
          ST_SYNC: begin
            if (!halfEnd) cnt <= cnt - CW'(1);
            else if (hi) begin
              hi  <= 1'b0;
              cnt <= CW'(HP_SYNC - 1);
            end else if (pop) begin
              shreg    <= rdData[7:0];
              lastFlag <= rdData[8];
              bitCnt   <= 3'd7;
              hi       <= 1'b1;
              cnt      <= halfOf(rdData[7]);
`ifdef TAPE_CHECKSUM_EN
              csum     <= csum ^ rdData[7:0];
`endif
            end else begin
              bitCnt   <= '0;
              lastFlag <= 1'b0;
            end
          end
          ST_DATA: begin
            if (!halfEnd) cnt <= cnt - CW'(1);
            else if (hi) begin
              hi  <= 1'b0;
              cnt <= halfOf(shreg[7]);
            end else if (bitCnt != '0) begin
              bitCnt <= bitCnt - 3'd1;
              shreg  <= shreg << 1;
              hi     <= 1'b1;
              cnt    <= halfOf(shreg[6]);
            end else if (lastFlag) begin
`ifdef TAPE_CHECKSUM_EN
              if (!csPhase) begin
                csPhase <= 1'b1;
                shreg   <= csum;
                bitCnt  <= 3'd7;
                hi      <= 1'b1;
                cnt     <= halfOf(csum[7]);
              end else begin
                cnt <= CW'(GAP - 1);
              end
`else
              cnt <= CW'(GAP - 1);
`endif
            end else if (pop) begin
              shreg    <= rdData[7:0];
              lastFlag <= rdData[8];
              bitCnt   <= 3'd7;
              hi       <= 1'b1;
              cnt      <= halfOf(rdData[7]);
`ifdef TAPE_CHECKSUM_EN
              csum     <= csum ^ rdData[7:0];
`endif
            end
          end
          ST_GAP: begin
            if (!halfEnd) cnt <= cnt - CW'(1);
            else done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tape_player.sv
module tb_tape_player;
  localparam int DEPTH = 16, HP0 = 2, HP1 = 4, HP_PILOT = 3, PILOT_CYC = 2, HP_SYNC = 1, GAP = 5;
  localparam int PRE = 2 * PILOT_CYC + 2;

  logic clock = 1'b0, reset = 1'b1, ceIn = 1'b1, motorIn = 1'b0;
  logic ear, busy, done;
  tape_player_if tp();

  int vectors = 0, miscompares = 0;
  logic [7:0] blk[$];
  int expRuns[$];
  int runLen[$];
  bit runVal[$];
  int doneCnt, rdyRise, frozenBad;

  always #5 clock = ~clock;

  tape_player #(
    .DEPTH(DEPTH), .HP0(HP0), .HP1(HP1), .HP_PILOT(HP_PILOT),
    .PILOT_CYC(PILOT_CYC), .HP_SYNC(HP_SYNC), .GAP(GAP)
  ) dut (
    .clock(clock), .reset(reset), .ce(ceIn), .motor(motorIn),
    .tape(tp), .ear(ear), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected ear run lengths (in ce ticks) for the bytes in blk; the final
  // low half merges with the gap silence.
  task automatic build_model();
    logic [7:0] seq[$];
    int h;
    seq = blk;
`ifdef TAPE_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      foreach (blk[i]) x = x ^ blk[i];
      seq.push_back(x);
    end
`endif
    expRuns.delete();
    repeat (2 * PILOT_CYC) expRuns.push_back(HP_PILOT);
    repeat (2) expRuns.push_back(HP_SYNC);
    foreach (seq[i])
      for (int j = 7; j >= 0; j--) begin
        h = seq[i][j] ? HP1 : HP0;
        expRuns.push_back(h);
        expRuns.push_back(h);
      end
    expRuns[expRuns.size() - 1] += GAP;
  endtask

  // -1 all runs match, -2 run count differs, else first bad run index.
  // At index skip the run only has to be longer than the model value.
  function automatic int first_mismatch(input int skip);
    if (runLen.size() != expRuns.size()) return -2;
    foreach (expRuns[i]) begin
      if (runVal[i] != (i % 2 == 0)) return i;
      if (i == skip) begin
        if (runLen[i] <= expRuns[i]) return i;
      end else if (runLen[i] != expRuns[i]) return i;
    end
    return -1;
  endfunction

  task automatic push_block(input bit markLast);
    motorIn = 1'b0;
    foreach (blk[i]) begin
      tp.di = blk[i];
      tp.dl = markLast && (i == blk.size() - 1);
      tp.dv = 1'b1;
      tick();
    end
    tp.dv = 1'b0;
    tp.dl = 1'b0;
  endtask

  // Runs the player until done (or budget), recording ear on every ce&motor
  // tick as run lengths. Leaves motor at 0 afterwards.
  task automatic capture(input int ceProb, input int motorProb, input int pauseAt,
                         input int pauseLen, input int pushAt, input logic [7:0] pushByte,
                         input bit pushLast, input int budget);
    bit curVal, have, pauseEar;
    int curLen;
    have = 0; curVal = 0; curLen = 0; pauseEar = 0;
    runLen.delete(); runVal.delete();
    doneCnt = 0; rdyRise = -1; frozenBad = 0;
    for (int k = 0; k < budget; k++) begin
      if (k == pushAt) begin
        tp.dv = 1'b1; tp.di = pushByte; tp.dl = pushLast;
      end else begin
        tp.dv = 1'b0; tp.dl = 1'b0;
      end
      if (pauseAt >= 0 && k >= pauseAt && k < pauseAt + pauseLen) motorIn = 1'b0;
      else motorIn = ($urandom_range(99) < motorProb);
      ceIn = ($urandom_range(99) < ceProb);
      if (k == pauseAt) pauseEar = ear;
      if (pauseAt >= 0 && k > pauseAt && k <= pauseAt + pauseLen)
        if (ear !== pauseEar || busy !== 1'b1) frozenBad++;
      if (ceIn && motorIn) begin
        if (have && ear == curVal) curLen++;
        else begin
          if (have) begin runVal.push_back(curVal); runLen.push_back(curLen); end
          curVal = ear; curLen = 1; have = 1;
        end
      end
      tick();
      if (tp.rdy && rdyRise < 0) rdyRise = k + 1;
      if (done) begin doneCnt++; break; end
    end
    if (have) begin runVal.push_back(curVal); runLen.push_back(curLen); end
    if (runVal.size() > 0 && runVal[0] == 1'b0) begin
      void'(runVal.pop_front());
      void'(runLen.pop_front());
    end
    tp.dv = 1'b0;
    motorIn = 1'b0;
    ceIn = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({ear, busy, done, tp.rdy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_async: {ear,busy,done,rdy}=%b required 0001", {ear, busy, done, tp.rdy});
    end
    tick(); tick();
    reset = 1'b1;
    ceIn = 1'b1; motorIn = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({ear, busy, done, tp.rdy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_idle: {ear,busy,done,rdy}=%b required 0001", {ear, busy, done, tp.rdy});
    end
    motorIn = 1'b0;
  endtask

  task automatic test_single_byte();
    int m;
    blk = {8'hA5};
    push_block(1);
    build_model();
    capture(100, 100, -1, 0, -1, 8'h00, 0, 2000);
    m = first_mismatch(-1);
    vectors++;
    if (m != -1) begin
      miscompares++;
      $display("FAIL single_a5 waveform: bad run %0d, got %0d runs, required %0d runs", m, runLen.size(), expRuns.size());
    end
    vectors++;
    if (doneCnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_a5 end: done pulses %0d busy %b, required 1 and 0", doneCnt, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_a5 done_width: done=%b one clock later, required 0", done);
    end
  endtask

  task automatic test_underrun();
    int m;
    blk = {8'h00};
    push_block(0);
    blk = {8'h00, 8'hFF};
    build_model();
    capture(100, 100, -1, 0, 80, 8'hFF, 1, 3000);
    m = first_mismatch(PRE + 15);
    vectors++;
    if (m != -1) begin
      miscompares++;
      $display("FAIL underrun waveform: bad run %0d, got %0d runs, required %0d runs", m, runLen.size(), expRuns.size());
    end
    vectors++;
    if (doneCnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun end: done pulses %0d busy %b, required 1 and 0", doneCnt, busy);
    end
  endtask

  task automatic test_motor_pause();
    int m;
    blk = {8'($urandom)};
    push_block(1);
    build_model();
    capture(100, 100, 6, 50, -1, 8'h00, 0, 3000);
    vectors++;
    if (frozenBad != 0) begin
      miscompares++;
      $display("FAIL motor_pause freeze: %0d cycles changed ear/busy, required 0", frozenBad);
    end
    m = first_mismatch(-1);
    vectors++;
    if (m != -1) begin
      miscompares++;
      $display("FAIL motor_pause waveform: bad run %0d, got %0d runs, required %0d runs", m, runLen.size(), expRuns.size());
    end
    vectors++;
    if (doneCnt != 1) begin
      miscompares++;
      $display("FAIL motor_pause done: pulses %0d, required 1", doneCnt);
    end
  endtask

  task automatic test_fifo_full();
    int m;
    logic [7:0] b;
    motorIn = 1'b0;
    blk.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) blk.push_back(b);
      tp.di = b; tp.dl = (i >= DEPTH - 1); tp.dv = 1'b1;
      if (i == DEPTH - 1) begin
        vectors++;
        if (tp.rdy !== 1'b1) begin
          miscompares++;
          $display("FAIL fifo_full rdy_before_last: rdy=%b required 1", tp.rdy);
        end
      end
      if (i == DEPTH) begin
        vectors++;
        if (tp.rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL fifo_full rdy_when_full: rdy=%b required 0", tp.rdy);
        end
      end
      tick();
    end
    tp.dv = 1'b0; tp.dl = 1'b0;
    build_model();
    capture(100, 100, -1, 0, -1, 8'h00, 0, 5000);
    vectors++;
    if (rdyRise != 1 + 2 * PILOT_CYC * HP_PILOT + 2 * HP_SYNC) begin
      miscompares++;
      $display("FAIL fifo_full rdy_rise: clock %0d, required %0d", rdyRise, 1 + 2 * PILOT_CYC * HP_PILOT + 2 * HP_SYNC);
    end
    m = first_mismatch(-1);
    vectors++;
    if (m != -1) begin
      miscompares++;
      $display("FAIL fifo_full waveform: bad run %0d, got %0d runs, required %0d runs", m, runLen.size(), expRuns.size());
    end
    vectors++;
    if (doneCnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full end: done pulses %0d busy %b, required 1 and 0", doneCnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$], b[$];
    int m;
    a = {8'($urandom), 8'($urandom)};
    b = {8'($urandom), 8'($urandom), 8'($urandom)};
    blk = a; push_block(1);
    blk = b; push_block(1);
    for (int n = 0; n < 2; n++) begin
      blk = (n == 0) ? a : b;
      build_model();
      capture(100, 100, -1, 0, -1, 8'h00, 0, 3000);
      m = first_mismatch(-1);
      vectors++;
      if (m != -1) begin
        miscompares++;
        $display("FAIL back_to_back block%0d waveform: bad run %0d, got %0d runs, required %0d", n, m, runLen.size(), expRuns.size());
      end
      vectors++;
      if (doneCnt != 1) begin
        miscompares++;
        $display("FAIL back_to_back block%0d done: pulses %0d, required 1", n, doneCnt);
      end
    end
  endtask

  task automatic test_random_blocks();
    int m, len;
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(1, 6);
      blk.delete();
      repeat (len) blk.push_back(8'($urandom));
      push_block(1);
      build_model();
      capture(60, 80, -1, 0, -1, 8'h00, 0, 20000);
      m = first_mismatch(-1);
      vectors++;
      if (m != -1) begin
        miscompares++;
        $display("FAIL random block%0d waveform: bad run %0d, got %0d runs, required %0d", n, m, runLen.size(), expRuns.size());
      end
      vectors++;
      if (doneCnt != 1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random block%0d end: done pulses %0d busy %b, required 1 and 0", n, doneCnt, busy);
      end
    end
  endtask

`ifdef TAPE_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] got;
    int m;
    blk = {8'h3C, 8'h5A};
    push_block(1);
    build_model();
    capture(100, 100, -1, 0, -1, 8'h00, 0, 3000);
    got = '0;
    if (runLen.size() >= PRE + 48)
      for (int j = 0; j < 8; j++) got[7 - j] = (runLen[PRE + 32 + 2 * j] == HP1);
    vectors++;
    if (got !== 8'h66) begin
      miscompares++;
      $display("FAIL checksum byte: got %02h, required 66", got);
    end
    m = first_mismatch(-1);
    vectors++;
    if (m != -1) begin
      miscompares++;
      $display("FAIL checksum waveform: bad run %0d, got %0d runs, required %0d", m, runLen.size(), expRuns.size());
    end
  endtask
`endif

  task automatic test_reset_mid_block();
    int bad;
    blk = {8'($urandom), 8'($urandom), 8'($urandom)};
    push_block(1);
    ceIn = 1'b1; motorIn = 1'b1;
    repeat (40) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset busy_before: busy=%b required 1", busy);
    end
    #3 reset = 1'b0;
    #1;
    vectors++;
    if ({ear, busy, done, tp.rdy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset async: {ear,busy,done,rdy}=%b required 0001", {ear, busy, done, tp.rdy});
    end
    repeat (2) tick();
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      tick();
      if (busy !== 1'b0 || ear !== 1'b0 || tp.rdy !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mid_reset stays_idle: %0d cycles not idle/empty, required 0", bad);
    end
  endtask

  initial begin
    tp.di = '0; tp.dv = 1'b0; tp.dl = 1'b0;
    test_reset();
    test_single_byte();
    test_underrun();
    test_motor_pause();
    test_fifo_full();
    test_back_to_back();
    test_random_blocks();
`ifdef TAPE_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
